// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver types: deframer states, prefix bytes and the scan codes
// the display stage acts on.
package ps2_pkg;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_t;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  localparam logic [7:0] UP    = 8'h75;
  localparam logic [7:0] DOWN  = 8'h72;
  localparam logic [7:0] LEFT  = 8'h6B;
  localparam logic [7:0] RIGHT = 8'h74;
  localparam logic [7:0] SPACE = 8'h29;

endpackage

// File: rtl/ps2_clk_filter.sv
// Input conditioning for the PS/2 pins: synchronises clock and data, debounces
// the clock and produces a one-cycle pulse on each filtered falling edge.
module ps2_clk_filter #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic data,
  output logic data_s,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_clk_q;
  logic [SYNC_STAGES-1:0] sync_dat_q;
  logic [FILTER_LEN-1:0]  hist_q;
  logic                   filt_q;
  logic                   fall_q;

  // Idle bus level is high, so everything resets to 1 to avoid a false edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_clk_q <= '1;
      sync_dat_q <= '1;
      hist_q     <= '1;
      filt_q     <= 1'b1;
      fall_q     <= 1'b0;
    end else begin
      sync_clk_q <= {sync_clk_q[SYNC_STAGES-2:0], ps2_clk};
      sync_dat_q <= {sync_dat_q[SYNC_STAGES-2:0], data};
      hist_q     <= {hist_q[FILTER_LEN-2:0], sync_clk_q[SYNC_STAGES-1]};
      fall_q     <= 1'b0;
      if (&hist_q) begin
        filt_q <= 1'b1;
      end else if (~|hist_q) begin
        filt_q <= 1'b0;
        fall_q <= filt_q;
      end
    end
  end

  assign data_s = sync_dat_q[SYNC_STAGES-1];
  assign fall   = fall_q;

endmodule

// File: rtl/ps2_scan_receiver.sv
// PS/2 device-to-host receiver: deframes 11-bit frames, checks parity and stop
// bit, folds E0/F0 prefixes into flags and emits one scan code per key event.
module ps2_scan_receiver
  import ps2_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       data,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       extended,
  output logic       released,
  output logic       frame_err
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES);

  logic            data_s;
  logic            fall;
  ps2_state_t      state_q;
  logic [2:0]      bit_cnt_q;
  logic [7:0]      shift_q;
  logic            par_ok_q;
  logic [TmoW-1:0] tmo_q;
  logic            ext_pend_q;
  logic            brk_pend_q;

  ps2_clk_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN)
  ) u_filter (
    .clk    (clk),
    .rst    (rst),
    .ps2_clk(ps2_clk),
    .data   (data),
    .data_s (data_s),
    .fall   (fall)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      par_ok_q   <= 1'b0;
      tmo_q      <= '0;
      ext_pend_q <= 1'b0;
      brk_pend_q <= 1'b0;
      code       <= 8'h00;
      code_valid <= 1'b0;
      extended   <= 1'b0;
      released   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      frame_err  <= 1'b0;

      if (fall || state_q == IDLE) begin
        tmo_q <= '0;
      end else begin
        tmo_q <= tmo_q + TmoW'(1);
      end

      // A falling edge in the terminal-count cycle takes priority over timeout.
      if (fall) begin
        unique case (state_q)
          IDLE: begin
            if (!data_s) begin
              state_q   <= DATA;
              bit_cnt_q <= 3'd0;
            end
          end
          DATA: begin
            shift_q   <= {data_s, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_q <= PARITY;
            end
          end
          PARITY: begin
            par_ok_q <= ^{shift_q, data_s};
            state_q  <= STOP;
          end
          STOP: begin
            state_q <= IDLE;
            if (data_s && par_ok_q) begin
              if (shift_q == PS2_EXT) begin
                ext_pend_q <= 1'b1;
              end else if (shift_q == PS2_BRK) begin
                brk_pend_q <= 1'b1;
              end else begin
                code       <= shift_q;
                extended   <= ext_pend_q;
                released   <= brk_pend_q;
                code_valid <= 1'b1;
                ext_pend_q <= 1'b0;
                brk_pend_q <= 1'b0;
              end
            end else begin
              frame_err  <= 1'b1;
              ext_pend_q <= 1'b0;
              brk_pend_q <= 1'b0;
            end
          end
          default: state_q <= IDLE;
        endcase
      end else if (state_q != IDLE && tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
        state_q    <= IDLE;
        frame_err  <= 1'b1;
        ext_pend_q <= 1'b0;
        brk_pend_q <= 1'b0;
      end
    end
  end

endmodule
